sd_sector_reader: RTL and testbench

AXI-Lite read master that streams whole 512-byte sectors out of the memory-mapped SD card slave (`sd_card_reader`), the read-side counterpart of the sector-writing master logic in the SD top level. On a start pulse it issues one single-beat 32-bit read per word across a run of consecutive sectors. Each returned word is forwarded on a valid/ready stream with a per-sector last flag. It sits between the SD slave's AR/R channels and any consumer, such as a boot loader, LED/debug checker or FIFO.

---
 rtl/sd_sector_reader.sv | 144 ++++++++++++++
 tb/tb_sd_sector_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_reader.sv
// AXI-Lite read master that streams consecutive 512-byte SD sectors, one
// single-beat 32-bit read at a time, onto a valid/ready stream with a per-sector last flag.
module sd_sector_reader #(
    parameter int WORDS_PER_SECTOR = 128,
    parameter int SECTOR_BYTES     = 512
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] start_sector,
    input  logic [15:0] num_sectors,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] m_axil_araddr,
    output logic [2:0]  m_axil_arprot,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last
);

    localparam int IDX_W = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_SECTOR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_OUT
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       addr_reg, addr_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [15:0]       remaining_reg, remaining_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [31:0]       data_reg, data_next;
    logic              last_reg, last_next;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            idx_reg       <= '0;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            data_reg      <= '0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            idx_reg       <= idx_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            data_reg      <= data_next;
            last_reg      <= last_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        idx_next       = idx_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        data_next      = data_reg;
        last_next      = last_reg;

        case (state_reg)
            S_IDLE: begin
                // The done cycle is still IDLE, so a start there must be ignored explicitly.
                if (start && !done_reg) begin
                    err_next       = 1'b0;
                    addr_next      = start_sector * 32'(SECTOR_BYTES);
                    idx_next       = '0;
                    remaining_next = num_sectors;
                    last_next      = 1'b0;
                    if (num_sectors == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (m_axil_arready) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axil_rvalid) begin
                    data_next  = m_axil_rdata;
                    last_next  = (idx_reg == LAST_IDX);
                    if (m_axil_rresp != 2'b00) begin
                        err_next = 1'b1;
                    end
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    if (last_reg && (remaining_reg == 16'd1)) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        addr_next  = addr_reg + 32'd4;
                        idx_next   = last_reg ? '0 : idx_reg + IDX_W'(1);
                        if (last_reg) begin
                            remaining_next = remaining_reg - 16'd1;
                        end
                        state_next = S_ADDR;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake strobes decode straight from the state, so they fall with reset.
    assign busy           = (state_reg != S_IDLE);
    assign done           = done_reg;
    assign err            = err_reg;
    assign m_axil_araddr  = addr_reg;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (state_reg == S_ADDR);
    assign m_axil_rready  = (state_reg == S_DATA);
    assign m_data         = data_reg;
    assign m_valid        = (state_reg == S_OUT);
    assign m_last         = last_reg;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Directed-then-randomized bench for sd_sector_reader: an AXI-Lite slave and stream
// consumer with random stalls, checked against an address/data model of whole sectors.
module tb_sd_sector_reader;

    localparam int W = 128;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_sector = '0;
    logic [15:0] num_sectors = '0;
    logic        busy, done, err;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;

    sd_sector_reader #(.WORDS_PER_SECTOR(W), .SECTOR_BYTES(512)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .start_sector(start_sector),
        .num_sectors(num_sectors), .busy(busy), .done(done), .err(err),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 aclk = ~aclk;

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Environment knobs and logs shared between the bus model and the test sequence.
    bit          stall_en = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] salt = '0;
    logic [31:0] ar_q[$];
    logic [31:0] d_q[$];
    bit          l_q[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cycles = 0;
    int          arvalid_cycles = 0;
    int          overlap_viol = 0;
    int          stab_viol = 0;
    int          err_hs_cyc = -1;
    int          err_rise_cyc = -1;

    bit          pending = 1'b0;
    logic [31:0] pend_addr = '0;
    bit          r_fire_prev = 1'b0;
    bit          err_prev = 1'b0;
    bit          astall_prev = 1'b0;
    logic [31:0] hold_addr = '0;
    bit          mstall_prev = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Sector memory contents as seen by the slave: the plain index pattern when salt is 0.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (salt == 32'd0) return 32'hFFFFA000 + ((a >> 2) & 32'h7F);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    // Slave + consumer + monitor. Runs at the falling edge; handshakes it records
    // are the ones that complete at the following rising edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            pending = 1'b0; r_fire_prev = 1'b0;
            arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; m_ready = 1'b0;
            astall_prev = 1'b0; mstall_prev = 1'b0; err_prev = 1'b0;
        end else begin
            if (busy) busy_cycles++;
            if (arvalid) arvalid_cycles++;
            if (arvalid && rready) overlap_viol++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err && !err_prev) err_rise_cyc = cyc;
            err_prev = err;

            if (r_fire_prev) begin rvalid = 1'b0; rresp = 2'b00; end
            if (pending && !rvalid && (!stall_en || $urandom_range(0, 2) == 0)) begin
                rvalid = 1'b1;
                rdata  = mem_word(pend_addr);
                rresp  = (err_en && pend_addr == err_addr) ? 2'b10 : 2'b00;
            end
            r_fire_prev = rvalid && rready;
            if (r_fire_prev) begin
                if (rresp != 2'b00) err_hs_cyc = cyc;
                pending = 1'b0;
            end

            if (astall_prev && (!arvalid || araddr !== hold_addr)) stab_viol++;
            arready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (arvalid && arready) begin
                ar_q.push_back(araddr);
                pending = 1'b1; pend_addr = araddr; astall_prev = 1'b0;
            end else begin
                astall_prev = arvalid; hold_addr = araddr;
            end

            if (mstall_prev && (!m_valid || m_data !== hold_data || m_last !== hold_last)) stab_viol++;
            m_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (m_valid && m_ready) begin
                d_q.push_back(m_data); l_q.push_back(m_last); mstall_prev = 1'b0;
            end else begin
                mstall_prev = m_valid; hold_data = m_data; hold_last = m_last;
            end
        end
    end

    int start_cyc = 0;

    task automatic tick;
        @(posedge aclk);
        #2;
    endtask

    task automatic clear_logs;
        ar_q.delete(); d_q.delete(); l_q.delete();
    endtask

    task automatic pulse_start(input logic [31:0] ss, input logic [15:0] ns);
        start_sector = ss; num_sectors = ns; start = 1'b1; start_cyc = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick;
        check({tag, " done seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    // Reference: a run is ns*W words at consecutive byte addresses from ss*512 (mod 2^32).
    task automatic check_run(input logic [31:0] ss, input int ns, input string tag);
        int n;
        longint unsigned base;
        n = ns * W;
        base = 64'(ss) * 64'd512;
        check({tag, " ar count"}, 32'(ar_q.size()), 32'(n));
        check({tag, " beat count"}, 32'(d_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            logic [31:0] ea;
            ea = 32'((base + 64'(k) * 64'd4) % 64'h1_0000_0000);
            if (k < ar_q.size()) check({tag, " araddr"}, ar_q[k], ea);
            if (k < d_q.size()) begin
                check({tag, " m_data"}, d_q[k], mem_word(ea));
                check({tag, " m_last"}, 32'(l_q[k]), 32'((k % W) == W - 1));
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " arvalid"}, 32'(arvalid), 32'd0);
        check({tag, " rready"}, 32'(rready), 32'd0);
        check({tag, " m_valid"}, 32'(m_valid), 32'd0);
        check({tag, " m_last"}, 32'(m_last), 32'd0);
        check({tag, " araddr"}, araddr, 32'd0);
        check({tag, " m_data"}, m_data, 32'd0);
    endtask

    initial begin
        logic [31:0] ss;
        int snap_arv, snap_busy, snap_done, snap_beats;
        bit found;

        // Reset state
        #1 aresetn = 1'b0;
        repeat (3) tick;
        check_outputs_zero("reset");
        check("reset arprot", 32'(arprot), 32'd0);
        aresetn = 1'b1;
        repeat (2) tick;

        // Single sector, zero wait, index pattern
        salt = '0; stall_en = 1'b0; clear_logs();
        pulse_start(32'd0, 16'd1);
        check("t1 busy cycle1", 32'(busy), 32'd1);
        check("t1 arvalid cycle1", 32'(arvalid), 32'd1);
        check("t1 araddr cycle1", araddr, 32'd0);
        wait_done(2000, "t1");
        check("t1 done latency", 32'(done_cyc - start_cyc), 32'd385);
        check("t1 err", 32'(err), 32'd0);
        check("t1 busy after", 32'(busy), 32'd0);
        check_run(32'd0, 1, "t1");
        $display("t1 single sector: %0d beats", d_q.size());

        // Back-pressure and wait states
        salt = $urandom | 32'd1; stall_en = 1'b1; clear_logs(); stab_viol = 0; overlap_viol = 0;
        pulse_start(32'd3, 16'd2);
        wait_done(20000, "t2");
        check_run(32'd3, 2, "t2");
        check("t2 stability", 32'(stab_viol), 32'd0);
        check("t2 ar/r overlap", 32'(overlap_viol), 32'd0);
        $display("t2 stalled two sectors: %0d beats", d_q.size());

        // Error response on word 5
        ss = 32'($urandom_range(0, 4000));
        salt = $urandom | 32'd1; err_en = 1'b1; err_addr = ss * 32'd512 + 32'd20;
        err_hs_cyc = -1; err_rise_cyc = -1; clear_logs();
        pulse_start(ss, 16'd1);
        wait_done(20000, "t3");
        check("t3 err rise latency", 32'(err_rise_cyc - err_hs_cyc), 32'd1);
        check("t3 err sticky after done", 32'(err), 32'd1);
        check_run(ss, 1, "t3");
        err_en = 1'b0;
        $display("t3 error word: rise at %0d after handshake at %0d", err_rise_cyc, err_hs_cyc);

        // Busy start ignored; err cleared by accepted start
        ss = 32'($urandom_range(0, 65535));
        salt = $urandom | 32'd1; clear_logs();
        pulse_start(ss, 16'd1);
        check("t4 err cleared", 32'(err), 32'd0);
        repeat (50) tick;
        pulse_start(ss + 32'd77, 16'd3);
        wait_done(20000, "t4");
        check_run(ss, 1, "t4");
        check("t4 stability", 32'(stab_viol), 32'd0);
        $display("t4 busy start ignored: %0d beats", d_q.size());

        // Zero count, then start during the done cycle
        stall_en = 1'b0; clear_logs();
        snap_arv = arvalid_cycles; snap_busy = busy_cycles; snap_done = done_cnt;
        pulse_start(32'd5, 16'd0);
        check("t5 done next cycle", 32'(done), 32'd1);
        check("t5 busy low", 32'(busy), 32'd0);
        pulse_start(32'd9, 16'd1);
        repeat (10) tick;
        check("t5 no arvalid", 32'(arvalid_cycles - snap_arv), 32'd0);
        check("t5 no busy", 32'(busy_cycles - snap_busy), 32'd0);
        check("t5 one done", 32'(done_cnt - snap_done), 32'd1);
        check("t5 no reads", 32'(ar_q.size()), 32'd0);
        $display("t5 zero count: done pulses %0d", done_cnt - snap_done);

        // Address wrap across 2^32, then a random high sector index (truncated product)
        salt = $urandom | 32'd1; stall_en = 1'b1; clear_logs();
        pulse_start(32'h007F_FFFF, 16'd2);
        wait_done(20000, "t6");
        check_run(32'h007F_FFFF, 2, "t6");
        $display("t6 wrap: first %h", (ar_q.size() > 0) ? ar_q[0] : 32'd0);
        ss = $urandom; stall_en = 1'b0; clear_logs();
        pulse_start(ss, 16'd1);
        wait_done(2000, "t7");
        check("t7 done latency", 32'(done_cyc - start_cyc), 32'd385);
        check_run(ss, 1, "t7");
        $display("t7 sector %h: %0d beats", ss, d_q.size());

        // Reset in DATA with rready high
        salt = $urandom | 32'd1; stall_en = 1'b1; clear_logs();
        pulse_start(32'd11, 16'd2);
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (rready && d_q.size() >= 3) found = 1'b1;
            else tick;
        end
        check("t8 reached DATA", 32'(found), 32'd1);
        snap_beats = d_q.size(); snap_done = done_cnt;
        aresetn = 1'b0;
        #1;
        check_outputs_zero("t8 async reset");
        repeat (3) tick;
        check("t8 no beat in reset", 32'(d_q.size()), 32'(snap_beats));
        check("t8 no done in reset", 32'(done_cnt), 32'(snap_done));
        aresetn = 1'b1;
        tick;
        ss = 32'($urandom_range(0, 1000)); stall_en = 1'b0; clear_logs();
        pulse_start(ss, 16'd1);
        wait_done(2000, "t8");
        check("t8 done latency", 32'(done_cyc - start_cyc), 32'd385);
        check_run(ss, 1, "t8");
        $display("t8 reset recovery: %0d beats", d_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
